// File: rtl/vip_bit_morph_3x3.sv
// vip_bit_morph_3x3: 3x3 binary erosion/dilation over a vsync/href/clken 1-bit pixel stream,
// using two line buffers so the image is processed in a single pass with 2 clk latency.
module vip_bit_morph_3x3 #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int MORPH     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_Bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_Bit
);
    localparam int          AW    = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [10:0] X_MAX = 11'(IMG_HDISP - 1);
    localparam logic [10:0] Y_MAX = 11'(IMG_VDISP - 1);

    logic          href_q;
    logic [10:0]   x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [2:0]    top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic          win_ok_q, win_ok_d, bit_q, bit_d;
    logic [1:0]    vs_q, hs_q, ce_q;
    logic          lb1_q [IMG_HDISP];
    logic          lb2_q [IMG_HDISP];
    logic [AW-1:0] addr;
    logic [8:0]    win;
    logic          accept, fall;

    assign accept = per_frame_href & per_frame_clken;
    assign fall   = href_q & ~per_frame_href;
    assign addr   = x_cnt_q[AW-1:0];
    assign win    = {top_q, mid_q, bot_q};

    always_comb begin
        x_cnt_d  = fall ? 11'd0 : (accept && x_cnt_q != X_MAX) ? x_cnt_q + 11'd1 : x_cnt_q;
        y_cnt_d  = !per_frame_vsync ? 11'd0 : (fall && y_cnt_q != Y_MAX) ? y_cnt_q + 11'd1 : y_cnt_q;
        // columns run x-2 (bit 2) .. x (bit 0); rows y-2 / y-1 / y come from lb2 / lb1 / input
        top_d    = accept ? {top_q[1:0], lb2_q[addr]} : top_q;
        mid_d    = accept ? {mid_q[1:0], lb1_q[addr]} : mid_q;
        bot_d    = accept ? {bot_q[1:0], per_img_Bit} : bot_q;
        win_ok_d = accept ? (x_cnt_q >= 11'd2 && y_cnt_q >= 11'd2) : win_ok_q;
        bit_d    = win_ok_q & ((MORPH != 0) ? |win : &win);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q   <= 1'b0;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            top_q    <= '0;
            mid_q    <= '0;
            bot_q    <= '0;
            win_ok_q <= 1'b0;
            bit_q    <= 1'b0;
            vs_q     <= '0;
            hs_q     <= '0;
            ce_q     <= '0;
        end else begin
            href_q   <= per_frame_href;
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            top_q    <= top_d;
            mid_q    <= mid_d;
            bot_q    <= bot_d;
            win_ok_q <= win_ok_d;
            bit_q    <= bit_d;
            vs_q     <= {vs_q[0], per_frame_vsync};
            hs_q     <= {hs_q[0], per_frame_href};
            ce_q     <= {ce_q[0], per_frame_clken};
        end
    end

    // read-before-write: lb1 moves down into lb2 as the new row enters lb1
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[addr] <= lb1_q[addr];
            lb1_q[addr] <= per_img_Bit;
        end
    end

    assign post_frame_vsync = vs_q[1];
    assign post_frame_href  = hs_q[1];
    assign post_frame_clken = ce_q[1];
    assign post_img_Bit     = bit_q;
endmodule

// File: tb/tb_vip_bit_morph_3x3.sv
// tb_vip_bit_morph_3x3: erosion and dilation instances fed the same stream, checked against an
// image-level window model plus per-frame literal counts.
module tb_vip_bit_morph_3x3;
    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0, rst_n = 1'b1, vs = 1'b0, hs = 1'b0, ce = 1'b0, bi = 1'b0;
    logic [1:0] pv, ph, pc, pb;
    logic       img [0:H-1][0:W-1];
    int         tests = 0, fails = 0;
    logic       chk_on = 1'b0;
    int         exp_ones [2];
    int         exp_pulses = 48;

    always #5 clk = ~clk;

    vip_bit_morph_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H), .MORPH(0)) u_ero (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hs),
        .per_frame_clken(ce), .per_img_Bit(bi), .post_frame_vsync(pv[0]),
        .post_frame_href(ph[0]), .post_frame_clken(pc[0]), .post_img_Bit(pb[0]));

    vip_bit_morph_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H), .MORPH(1)) u_dil (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hs),
        .per_frame_clken(ce), .per_img_Bit(bi), .post_frame_vsync(pv[1]),
        .post_frame_href(ph[1]), .post_frame_clken(pc[1]), .post_img_Bit(pb[1]));

    task automatic chk(input string n, input int d, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", n, d, act, exp, $time);
        end
    endtask

    // output (x,y) is the 3x3 reduction of input columns x-2..x, rows y-2..y; border rows/cols are 0
    function automatic logic exp_pix(input int m, input int x, input int y);
        logic a = 1'b1, o = 1'b0;
        if (x < 2 || y < 2) return 1'b0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                a &= img[y-2+dy][x-2+dx];
                o |= img[y-2+dy][x-2+dx];
            end
        return (m != 0) ? o : a;
    endfunction

    logic [2:0] h0 = '0, h1 = '0;
    logic [1:0] prev_pv = '0, prev_ph = '0, prev_pb = '0;
    int         vcnt = 0, ox = 0, oy = 0, pulses = 0;
    int         ones [2] = '{0, 0};

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) chk("reset_outputs", i, int'({pv[i], ph[i], pc[i], pb[i]}), 0);
            vcnt = 0;
            ox = 0;
            oy = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (vcnt >= 2) chk("delay2_sync", i, int'({pv[i], ph[i], pc[i]}), int'(h1));
                if (vcnt >= 1 && !pc[i]) chk("hold_no_clken", i, int'(pb[i]), int'(prev_pb[i]));
            end
            if (vcnt >= 1 && prev_pv[0] && !pv[0] && chk_on) begin
                for (int i = 0; i < 2; i++) if (exp_ones[i] >= 0) chk("frame_ones", i, ones[i], exp_ones[i]);
                chk("frame_pulses", 0, pulses, exp_pulses);
            end
            if (vcnt >= 1 && !prev_pv[0] && pv[0]) begin
                ones = '{0, 0};
                pulses = 0;
            end
            if (!pv[0]) begin
                ox = 0;
                oy = 0;
            end else if (vcnt >= 1 && prev_ph[0] && !ph[0]) begin
                oy++;
                ox = 0;
            end
            if (pv[0] && ph[0] && pc[0]) begin
                pulses++;
                for (int i = 0; i < 2; i++) ones[i] += int'(pb[i]);
                if (chk_on) begin
                    chk("pos_in_range", 0, int'(ox < W && oy < H), 1);
                    if (ox < W && oy < H)
                        for (int i = 0; i < 2; i++) chk("pixel", i, int'(pb[i]), int'(exp_pix(i, ox, oy)));
                end
                ox++;
            end
            vcnt++;
        end
        h1 = h0;
        h0 = {vs, hs, ce};
        prev_pv = pv;
        prev_ph = ph;
        prev_pb = pb;
    end

    task automatic drv(input logic v, input logic h, input logic c, input logic b);
        @(posedge clk);
        #1;
        vs = v;
        hs = h;
        ce = c;
        bi = b;
    endtask

    task automatic fill(input logic v, input int hx, input int hy, input logic hv);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = v;
        if (hx >= 0) img[hy][hx] = hv;
    endtask

    task automatic frame(input int e0, input int e1, input logic on, input logic do_rst);
        repeat (26) drv(1'b0, 1'b0, 1'b0, 1'b0);
        chk_on = on;
        exp_ones[0] = e0;
        exp_ones[1] = e1;
        for (int y = 0; y < H; y++) begin
            repeat (5) drv(1'b1, 1'b0, 1'b0, 1'b0);
            for (int x = 0; x < W; x++) begin
                if (do_rst && y == 3 && x == 3) begin
                    @(posedge clk);
                    #1 rst_n = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 rst_n = 1'b1;
                end
                drv(1'b1, 1'b1, 1'b1, img[y][x]);
                drv(1'b1, 1'b1, 1'b0, 1'b0);
            end
            repeat (5) drv(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        fill(1'b1, -1, -1, 1'b0);
        frame(24, 24, 1'b1, 1'b0);
        fill(1'b0, 4, 2, 1'b1);
        frame(0, 9, 1'b1, 1'b0);
        fill(1'b1, 4, 3, 1'b0);
        frame(15, 24, 1'b1, 1'b0);
        fill(1'b1, -1, -1, 1'b0);
        frame(24, 24, 1'b1, 1'b0);
        fill(1'b0, -1, -1, 1'b0);
        frame(0, 0, 1'b1, 1'b0);
        fill(1'b1, -1, -1, 1'b0);
        frame(-1, -1, 1'b0, 1'b1);
        frame(24, 24, 1'b1, 1'b0);
        repeat (30) drv(1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
